// File: rtl/i_prefetch_pkg.sv
// Shared types and helpers for the next-line instruction prefetch buffer.
// Holds the controller state encoding and the next-line address arithmetic.
package i_prefetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FWD_REQ,
    FWD_DATA,
    SERVE,
    PF_REQ,
    PF_DATA
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LINE_BYTES = WORD_BYTES << 2;

  // Callers truncate the result to their address width, giving modulo wrap.
  function automatic logic [31:0] next_line(input logic [31:0] addr,
                                            input int unsigned line_bytes);
    return addr + line_bytes;
  endfunction

endpackage

// File: rtl/i_prefetch_buffer_if.sv
// AXI-style read address/data channel bundle used on both the i_cache side
// and the memory side of the prefetch buffer.
interface i_prefetch_buffer_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [3:0]            arid;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arlen, arid, arvalid, rready,
        input  arready, rdata, rvalid
    );

    modport slave (
        input  araddr, arlen, arid, arvalid, rready,
        output arready, rdata, rvalid
    );
endinterface

// File: rtl/prefetch_line_buf.sv
// One-line storage for the prefetched cache line: word array plus the line
// address tag and its valid flag.
module prefetch_line_buf #(
    parameter int ADDR_WIDTH         = 26,
    parameter int DATA_WIDTH         = 32,
    parameter int BLOCK_OFFSET_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [BLOCK_OFFSET_WIDTH-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [BLOCK_OFFSET_WIDTH-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          load,
    input  logic [ADDR_WIDTH-1:0]         load_addr,
    input  logic                          load_valid,
    input  logic                          clr,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic                          valid
);
    localparam int LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH;

    logic [DATA_WIDTH-1:0] words [LINE_SIZE];

    always_ff @(posedge clk) begin
        if (wr_en) words[wr_idx] <= wr_data;
        if (load)  addr <= load_addr;
    end

    assign rd_data = words[rd_idx];

    // Clear beats load so an invalidate on the final prefetch beat still wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    valid <= 1'b0;
        else if (clr)  valid <= 1'b0;
        else if (load) valid <= load_valid;
    end
endmodule

// File: rtl/i_prefetch_buffer.sv
// Next-line instruction stream buffer: forwards i_cache refills to memory,
// prefetches the following line and serves a matching refill locally.
module i_prefetch_buffer
    import i_prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH         = 26,
    parameter int DATA_WIDTH         = 32,
    parameter int BLOCK_OFFSET_WIDTH = 2,
    parameter int PREFETCH_EN        = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    i_prefetch_buffer_if.slave      s_bus,
    i_prefetch_buffer_if.master     m_bus,
    input  logic                    i_invalidate,
    output logic [31:0]             o_hit_count,
    output logic [31:0]             o_miss_count
);
    localparam int LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH;
    localparam int unsigned LINE_B = WORD_BYTES << BLOCK_OFFSET_WIDTH;
    localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_IDX = '1;
    localparam logic [BLOCK_OFFSET_WIDTH-1:0] ONE      = BLOCK_OFFSET_WIDTH'(1);

    state_t                        state;
    logic [BLOCK_OFFSET_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0]         ar_addr;
    logic                          inv_seen;
    logic [ADDR_WIDTH-1:0]         buf_addr;
    logic                          buf_valid;
    logic [DATA_WIDTH-1:0]         buf_rdata;
    logic                          accept, hit, last_idx, pf_beat;
    logic                          unused_upstream;

    assign accept   = (state == IDLE) && s_bus.arvalid;
    assign hit      = buf_valid && (buf_addr == s_bus.araddr) && !i_invalidate;
    assign last_idx = (cnt == LAST_IDX);
    assign pf_beat  = (state == PF_DATA) && m_bus.rvalid;

    // Upstream burst length, id and ready are fixed by the i_cache.
    assign unused_upstream = ^{s_bus.arlen, s_bus.arid, s_bus.rready};

    prefetch_line_buf #(
        .ADDR_WIDTH        (ADDR_WIDTH),
        .DATA_WIDTH        (DATA_WIDTH),
        .BLOCK_OFFSET_WIDTH(BLOCK_OFFSET_WIDTH)
    ) u_line_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (pf_beat),
        .wr_idx    (cnt),
        .wr_data   (m_bus.rdata),
        .rd_idx    (cnt),
        .rd_data   (buf_rdata),
        .load      (pf_beat && last_idx),
        .load_addr (ar_addr),
        .load_valid(!inv_seen && !i_invalidate),
        .clr       (i_invalidate || (accept && hit)),
        .addr      (buf_addr),
        .valid     (buf_valid)
    );

    assign s_bus.arready = (state == IDLE);
    assign s_bus.rvalid  = ((state == FWD_DATA) && m_bus.rvalid) || (state == SERVE);
    assign s_bus.rdata   = (state == FWD_DATA) ? m_bus.rdata : buf_rdata;
    assign m_bus.arvalid = (state == FWD_REQ) || (state == PF_REQ);
    assign m_bus.araddr  = ar_addr;
    assign m_bus.arlen   = 8'(LINE_SIZE);
    assign m_bus.arid    = 4'd0;
    assign m_bus.rready  = (state == FWD_DATA) || (state == PF_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            ar_addr      <= '0;
            inv_seen     <= 1'b0;
            o_hit_count  <= 32'd0;
            o_miss_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (hit) begin
                            state       <= SERVE;
                            o_hit_count <= o_hit_count + 32'd1;
                        end else begin
                            state        <= FWD_REQ;
                            ar_addr      <= s_bus.araddr;
                            o_miss_count <= o_miss_count + 32'd1;
                        end
                    end
                end
                FWD_REQ: begin
                    if (m_bus.arready) begin
                        state <= FWD_DATA;
                        cnt   <= '0;
                    end
                end
                FWD_DATA: begin
                    if (m_bus.rvalid) begin
                        cnt <= cnt + ONE;
                        if (last_idx) begin
                            cnt      <= '0;
                            inv_seen <= 1'b0;
                            if (PREFETCH_EN != 0) begin
                                state   <= PF_REQ;
                                ar_addr <= ADDR_WIDTH'(next_line(32'(ar_addr), LINE_B));
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                SERVE: begin
                    cnt <= cnt + ONE;
                    if (last_idx) begin
                        cnt      <= '0;
                        inv_seen <= 1'b0;
                        if (PREFETCH_EN != 0) begin
                            state   <= PF_REQ;
                            ar_addr <= ADDR_WIDTH'(next_line(32'(buf_addr), LINE_B));
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                PF_REQ: begin
                    if (i_invalidate) inv_seen <= 1'b1;
                    if (m_bus.arready) begin
                        state <= PF_DATA;
                        cnt   <= '0;
                    end
                end
                PF_DATA: begin
                    if (i_invalidate) inv_seen <= 1'b1;
                    if (m_bus.rvalid) begin
                        cnt <= cnt + ONE;
                        if (last_idx) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i_prefetch_buffer.sv
// Directed bench for i_prefetch_buffer: a table of refill transactions plus
// hand-written sequences for mid-prefetch arrival, invalidate and reset.
module tb_i_prefetch_buffer;
    logic        clk;
    logic        rst_n;
    logic        i_invalidate;
    logic [31:0] hit_cnt, miss_cnt;
    int          n_pass, n_total;

    i_prefetch_buffer_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) us ();
    i_prefetch_buffer_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) ms ();

    i_prefetch_buffer #(
        .ADDR_WIDTH(26), .DATA_WIDTH(32), .BLOCK_OFFSET_WIDTH(2), .PREFETCH_EN(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_bus       (us),
        .m_bus       (ms),
        .i_invalidate(i_invalidate),
        .o_hit_count (hit_cnt),
        .o_miss_count(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] addr;
        bit          hit;
        logic [25:0] pf;
        int          hits;
        int          misses;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [31:0] mem_word(input logic [25:0] a, input int i);
        logic [25:0] wa;
        wa = a + 26'(i * 4);
        return 32'hA000_0000 | {6'd0, wa};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic timeout_fail(input string nm);
        n_total++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_accept(input logic [25:0] addr, input logic inv);
        int n;
        us.araddr    = addr;
        us.arvalid   = 1'b1;
        i_invalidate = inv;
        for (n = 0; n < 40; n++) begin
            #1;
            if (us.arready) break;
            @(negedge clk);
        end
        if (n == 40) timeout_fail("accept");
        @(negedge clk);
        us.arvalid   = 1'b0;
        i_invalidate = 1'b0;
    endtask

    task automatic wait_ar(input logic [25:0] exp, input string nm);
        int n;
        for (n = 0; n < 20; n++) begin
            #1;
            if (ms.arvalid) break;
            @(negedge clk);
        end
        if (n == 20) begin
            timeout_fail(nm);
        end else begin
            check(nm, 32'(ms.araddr), 32'(exp));
            check("m_arlen", 32'(ms.arlen), 32'd4);
            check("m_arid", 32'(ms.arid), 32'd0);
            ms.arready = 1'b1;
            @(negedge clk);
            ms.arready = 1'b0;
        end
    endtask

    task automatic beat(input logic [31:0] d, input bit pass);
        ms.rvalid = 1'b1;
        ms.rdata  = d;
        #1;
        check("m_rready", 32'(ms.rready), 32'd1);
        if (pass) begin
            check("fwd_rvalid", 32'(us.rvalid), 32'd1);
            check("fwd_rdata", us.rdata, d);
        end else begin
            check("pf_no_rvalid", 32'(us.rvalid), 32'd0);
        end
        @(negedge clk);
        ms.rvalid = 1'b0;
    endtask

    task automatic pf_burst(input logic [25:0] pf, input int inv_beat);
        wait_ar(pf, "pf_araddr");
        for (int i = 0; i < 4; i++) begin
            if (i == inv_beat) i_invalidate = 1'b1;
            beat(mem_word(pf, i), 1'b0);
            i_invalidate = 1'b0;
        end
    endtask

    task automatic full_miss(input logic [25:0] addr, input logic [25:0] pf,
                             input logic inv_accept, input int inv_beat);
        do_accept(addr, inv_accept);
        wait_ar(addr, "miss_araddr");
        for (int i = 0; i < 4; i++) beat(mem_word(addr, i), 1'b1);
        pf_burst(pf, inv_beat);
    endtask

    task automatic full_hit(input logic [25:0] addr, input logic [25:0] pf);
        do_accept(addr, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("hit_rvalid", 32'(us.rvalid), 32'd1);
            check("hit_rdata", us.rdata, mem_word(addr, i));
            check("hit_no_arvalid", 32'(ms.arvalid), 32'd0);
            @(negedge clk);
        end
        pf_burst(pf, -1);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        tbl[0] = '{26'h000100, 1'b0, 26'h000110, 0, 1};
        tbl[1] = '{26'h000110, 1'b1, 26'h000120, 1, 1};
        tbl[2] = '{26'h000120, 1'b1, 26'h000130, 2, 1};
        tbl[3] = '{26'h000500, 1'b0, 26'h000510, 2, 2};
        tbl[4] = '{26'h3FFFFF0, 1'b0, 26'h0000000, 2, 3};
        tbl[5] = '{26'h0000000, 1'b1, 26'h0000010, 3, 3};

        rst_n = 1'b0;
        i_invalidate = 1'b0;
        us.araddr = '0; us.arlen = 8'd4; us.arid = 4'd0; us.arvalid = 1'b0; us.rready = 1'b1;
        ms.arready = 1'b0; ms.rdata = '0; ms.rvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_arready", 32'(us.arready), 32'd1);
        check("rst_rvalid", 32'(us.rvalid), 32'd0);
        check("rst_m_arvalid", 32'(ms.arvalid), 32'd0);
        check("rst_m_rready", 32'(ms.rready), 32'd0);
        check("rst_hits", hit_cnt, 32'd0);
        check("rst_misses", miss_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            if (tbl[k].hit) full_hit(tbl[k].addr, tbl[k].pf);
            else            full_miss(tbl[k].addr, tbl[k].pf, 1'b0, -1);
            check($sformatf("t%0d_hits", k), hit_cnt, 32'(tbl[k].hits));
            check($sformatf("t%0d_misses", k), miss_cnt, 32'(tbl[k].misses));
        end

        // Request arriving while the prefetch of 0x610 is streaming in.
        do_accept(26'h000600, 1'b0);
        wait_ar(26'h000600, "a_miss_araddr");
        for (int i = 0; i < 4; i++) beat(mem_word(26'h000600, i), 1'b1);
        wait_ar(26'h000610, "a_pf_araddr");
        beat(mem_word(26'h000610, 0), 1'b0);
        beat(mem_word(26'h000610, 1), 1'b0);
        us.araddr  = 26'h000200;
        us.arvalid = 1'b1;
        #1;
        check("a_arready_mid_pf", 32'(us.arready), 32'd0);
        beat(mem_word(26'h000610, 2), 1'b0);
        #1;
        check("a_arready_last_pf", 32'(us.arready), 32'd0);
        beat(mem_word(26'h000610, 3), 1'b0);
        #1;
        check("a_arready_after_pf", 32'(us.arready), 32'd1);
        full_miss(26'h000200, 26'h000210, 1'b0, -1);
        check("a_hits", hit_cnt, 32'd3);
        check("a_misses", miss_cnt, 32'd5);

        // Invalidate during the prefetch data phase, then invalidate racing a hit.
        full_miss(26'h000700, 26'h000710, 1'b0, 1);
        full_miss(26'h000710, 26'h000720, 1'b0, -1);
        check("b_hits_after_inv_pf", hit_cnt, 32'd3);
        check("b_misses_after_inv_pf", miss_cnt, 32'd7);
        full_miss(26'h000720, 26'h000730, 1'b1, -1);
        check("b_hits_inv_accept", hit_cnt, 32'd3);
        check("b_misses_inv_accept", miss_cnt, 32'd8);

        // Asynchronous reset on the third forwarded beat, with stray beats after.
        do_accept(26'h000800, 1'b0);
        wait_ar(26'h000800, "c_miss_araddr");
        beat(mem_word(26'h000800, 0), 1'b1);
        beat(mem_word(26'h000800, 1), 1'b1);
        ms.rvalid = 1'b1;
        ms.rdata  = mem_word(26'h000800, 2);
        rst_n     = 1'b0;
        #1;
        check("c_rst_rvalid", 32'(us.rvalid), 32'd0);
        check("c_rst_m_rready", 32'(ms.rready), 32'd0);
        check("c_rst_arready", 32'(us.arready), 32'd1);
        check("c_rst_hits", hit_cnt, 32'd0);
        check("c_rst_misses", miss_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ms.rdata = mem_word(26'h000800, 3);
        #1;
        check("c_stray_rvalid", 32'(us.rvalid), 32'd0);
        check("c_stray_m_rready", 32'(ms.rready), 32'd0);
        @(negedge clk);
        #1;
        check("c_stray_idle", 32'(us.arready), 32'd1);
        check("c_stray_arvalid", 32'(ms.arvalid), 32'd0);
        ms.rvalid = 1'b0;
        @(negedge clk);
        full_miss(26'h000730, 26'h000740, 1'b0, -1);
        check("c_post_rst_hits", hit_cnt, 32'd0);
        check("c_post_rst_misses", miss_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
